// File: rtl/i2c_camera_target.sv
`timescale 1ns/1ps
// I2C register-access target for a camera sensor control port.
// Decodes device address, one or two register address bytes, then
// streams write bytes out as register strobes or serves read bytes
// fetched through a one-Clk read request. SDA is open-drain (0 or z).
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | bus free, waiting for START
// DEV     | shifting in device address + R/W bit
// DEV_ACK | acknowledging device address
// AH      | shifting in register address high byte
// AH_ACK  | acknowledging address high byte
// AL      | shifting in register address low byte
// AL_ACK  | acknowledging address low byte
// WR      | shifting in a write data byte
// WR_ACK  | acknowledging write byte, address bumps at its end
// RD      | shifting out a read data byte
// RD_ACK  | sampling master ACK/NACK after a read byte
// WAIT    | not addressed or NACKed, ignore bus until START/STOP
module i2c_camera_target #(
   parameter logic [7:0] DEVICE_ID = 8'h78,
   parameter int         ADDR_MODE = 1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        i2c_sclk,
   inout  wire         i2c_sdat,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wrdata,
   output logic        reg_wr_en,
   output logic        reg_rd_en,
   input  logic [7:0]  reg_rddata,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WR, WR_ACK, RD, RD_ACK, WAIT
   } state_t;

   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t      state, state_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  rx_sr, rx_sr_nxt;
   logic [7:0]  tx_sr, tx_sr_nxt;
   logic        ack_hold, ack_hold_nxt;
   logic        rw, rw_nxt;
   logic        sda_oe, sda_oe_nxt;
   logic [15:0] addr_nxt;
   logic [7:0]  wrdata_nxt;
   logic        wr_en_nxt, rd_en_nxt;
   logic [7:0]  rx_byte;
   logic [15:0] addr_inc;

   // Two-flop synchronizers plus one extra stage for edge detection.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_d  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_s1 <= i2c_sclk;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= i2c_sdat;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
      end
   end

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

   assign rx_byte  = {rx_sr[6:0], sda_s2};
   // In 8-bit address mode the upper byte stays zero and the low byte wraps.
   assign addr_inc = (ADDR_MODE == 1) ? (reg_addr + 16'd1)
                                      : {8'h00, reg_addr[7:0] + 8'd1};

   assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
   assign busy     = (state != IDLE) && (state != WAIT) && (state != DEV);

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         rx_sr      <= 8'h00;
         tx_sr      <= 8'h00;
         ack_hold   <= 1'b0;
         rw         <= 1'b0;
         sda_oe     <= 1'b0;
         reg_addr   <= 16'h0000;
         reg_wrdata <= 8'h00;
         reg_wr_en  <= 1'b0;
         reg_rd_en  <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         rx_sr      <= rx_sr_nxt;
         tx_sr      <= tx_sr_nxt;
         ack_hold   <= ack_hold_nxt;
         rw         <= rw_nxt;
         sda_oe     <= sda_oe_nxt;
         reg_addr   <= addr_nxt;
         reg_wrdata <= wrdata_nxt;
         reg_wr_en  <= wr_en_nxt;
         reg_rd_en  <= rd_en_nxt;
      end
   end

   // Next-state and output decode. ack_hold marks that the ACK bit's first
   // falling edge has passed (target ACK driven, or master ACK seen in RD_ACK).
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      rx_sr_nxt    = rx_sr;
      tx_sr_nxt    = reg_rd_en ? reg_rddata : tx_sr;
      ack_hold_nxt = ack_hold;
      rw_nxt       = rw;
      sda_oe_nxt   = sda_oe;
      addr_nxt     = reg_addr;
      wrdata_nxt   = reg_wrdata;
      wr_en_nxt    = 1'b0;
      rd_en_nxt    = 1'b0;

      if (stop_det) begin
         state_nxt    = IDLE;
         bit_cnt_nxt  = 3'd0;
         ack_hold_nxt = 1'b0;
         sda_oe_nxt   = 1'b0;
      end else if (start_det) begin
         // Repeated START keeps reg_addr so write-address-then-read works.
         state_nxt    = DEV;
         bit_cnt_nxt  = 3'd0;
         ack_hold_nxt = 1'b0;
         sda_oe_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE, WAIT: begin
            end

            DEV, AH, AL, WR: begin
               if (scl_rise) begin
                  rx_sr_nxt   = rx_byte;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_hold_nxt = 1'b0;
                     if (state == DEV) begin
                        if (rx_byte[7:1] == DEVICE_ID[7:1]) begin
                           state_nxt = DEV_ACK;
                           rw_nxt    = rx_byte[0];
                        end else begin
                           state_nxt = WAIT;
                        end
                     end else if (state == AH) begin
                        addr_nxt[15:8] = rx_byte;
                        state_nxt      = AH_ACK;
                     end else if (state == AL) begin
                        addr_nxt  = (ADDR_MODE == 1) ? {reg_addr[15:8], rx_byte}
                                                     : {8'h00, rx_byte};
                        state_nxt = AL_ACK;
                     end else begin
                        wrdata_nxt = rx_byte;
                        wr_en_nxt  = 1'b1;
                        state_nxt  = WR_ACK;
                     end
                  end
               end
            end

            DEV_ACK, AH_ACK, AL_ACK, WR_ACK: begin
               if (scl_rise && (state == DEV_ACK) && rw && ack_hold)
                  rd_en_nxt = 1'b1;
               if (scl_fall) begin
                  if (!ack_hold) begin
                     sda_oe_nxt   = 1'b1;
                     ack_hold_nxt = 1'b1;
                  end else begin
                     ack_hold_nxt = 1'b0;
                     bit_cnt_nxt  = 3'd0;
                     sda_oe_nxt   = 1'b0;
                     if (state == DEV_ACK) begin
                        if (rw) begin
                           state_nxt  = RD;
                           sda_oe_nxt = ~tx_sr[7];
                        end else if (ADDR_MODE == 1) begin
                           state_nxt = AH;
                        end else begin
                           state_nxt = AL;
                        end
                     end else if (state == AH_ACK) begin
                        state_nxt = AL;
                     end else if (state == AL_ACK) begin
                        state_nxt = WR;
                     end else begin
                        state_nxt = WR;
                        addr_nxt  = addr_inc;
                     end
                  end
               end
            end

            RD: begin
               if (scl_fall) begin
                  tx_sr_nxt  = {tx_sr[6:0], 1'b0};
                  sda_oe_nxt = ~tx_sr[6];
               end
               if (scl_rise) begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state_nxt    = RD_ACK;
                     bit_cnt_nxt  = 3'd0;
                     ack_hold_nxt = 1'b0;
                  end
               end
            end

            RD_ACK: begin
               if (scl_fall) begin
                  if (!ack_hold) begin
                     sda_oe_nxt = 1'b0;
                  end else begin
                     state_nxt    = RD;
                     ack_hold_nxt = 1'b0;
                     bit_cnt_nxt  = 3'd0;
                     sda_oe_nxt   = ~tx_sr[7];
                  end
               end
               if (scl_rise && !ack_hold) begin
                  if (!sda_s2) begin
                     addr_nxt     = addr_inc;
                     rd_en_nxt    = 1'b1;
                     ack_hold_nxt = 1'b1;
                  end else begin
                     state_nxt  = WAIT;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end

            default: begin
               state_nxt  = IDLE;
               sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_camera_target.sv
`timescale 1ns/1ps
// Bench for i2c_camera_target: a bit-banged I2C master drives two targets
// (16-bit and 8-bit address mode) on separate buses. Expected strobes and
// read bytes come from a plain address/memory model.
module tb_i2c_camera_target;

   localparam int Q = 50;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        m_scl, m_sda_oe, sel;
   logic        scl_a, scl_b, sda_in;
   wire         sda_a, sda_b;
   logic [15:0] addr_a, addr_b;
   logic [7:0]  wrdata_a, wrdata_b, rddata_a, rddata_b;
   logic        wr_en_a, wr_en_b, rd_en_a, rd_en_b, busy_a, busy_b;

   logic [7:0]  mem [0:65535];
   logic [23:0] wr_q_a[$];
   logic [23:0] wr_q_b[$];
   logic [15:0] rd_q_a[$];
   logic [15:0] rd_q_b[$];
   int          busy_cnt_a;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 Clk = ~Clk;

   pullup pu_a (sda_a);
   pullup pu_b (sda_b);

   assign scl_a    = sel ? 1'b1 : m_scl;
   assign scl_b    = sel ? m_scl : 1'b1;
   assign sda_a    = (m_sda_oe && !sel) ? 1'b0 : 1'bz;
   assign sda_b    = (m_sda_oe && sel) ? 1'b0 : 1'bz;
   assign sda_in   = sel ? sda_b : sda_a;
   assign rddata_a = mem[addr_a];
   assign rddata_b = mem[addr_b];

   i2c_camera_target #(.DEVICE_ID(8'h78), .ADDR_MODE(1)) dut_a (
      .Clk(Clk), .Rst_n(Rst_n), .i2c_sclk(scl_a), .i2c_sdat(sda_a),
      .reg_addr(addr_a), .reg_wrdata(wrdata_a), .reg_wr_en(wr_en_a),
      .reg_rd_en(rd_en_a), .reg_rddata(rddata_a), .busy(busy_a));

   i2c_camera_target #(.DEVICE_ID(8'h78), .ADDR_MODE(0)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n), .i2c_sclk(scl_b), .i2c_sdat(sda_b),
      .reg_addr(addr_b), .reg_wrdata(wrdata_b), .reg_wr_en(wr_en_b),
      .reg_rd_en(rd_en_b), .reg_rddata(rddata_b), .busy(busy_b));

   // Record every strobe so pulse count, address and data can be checked.
   always @(posedge Clk) begin
      if (wr_en_a) wr_q_a.push_back({addr_a, wrdata_a});
      if (wr_en_b) wr_q_b.push_back({addr_b, wrdata_b});
      if (rd_en_a) rd_q_a.push_back(addr_a);
      if (rd_en_b) rd_q_b.push_back(addr_b);
      if (busy_a) busy_cnt_a++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, output logic r);
      m_sda_oe = !b;
      #Q; m_scl = 1'b1;
      #Q; r = sda_in;
      #Q; m_scl = 1'b0;
      #Q;
   endtask

   task automatic start_c();
      m_sda_oe = 1'b0;
      #Q; m_scl = 1'b1;
      #Q; m_sda_oe = 1'b1;
      #Q; m_scl = 1'b0;
      #Q;
   endtask

   task automatic stop_c();
      m_sda_oe = 1'b1;
      #Q; m_scl = 1'b1;
      #Q; m_sda_oe = 1'b0;
      #Q; #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(d[i], r);
      send_bit(1'b1, r);
      acked = (r === 1'b0);
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, r);
         d[i] = r;
      end
      send_bit(!give_ack, r);
   endtask

   function automatic logic [31:0] wr_at(input int i);
      return (i < wr_q_a.size()) ? {8'h00, wr_q_a[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] rd_at(input int i);
      return (i < rd_q_a.size()) ? {16'h0000, rd_q_a[i]} : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic        ak, r;
      int          acks, n;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  pay [0:3];

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h300A] = 8'h56;
      mem[16'h300B] = 8'h40;

      Rst_n = 1'b0; m_scl = 1'b1; m_sda_oe = 1'b0; sel = 1'b0;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      check("rst_addr", {16'h0, addr_a}, 32'h0);
      check("rst_wrdata", {24'h0, wrdata_a}, 32'h0);
      check("rst_wr_en", {31'h0, wr_en_a}, 32'h0);
      check("rst_rd_en", {31'h0, rd_en_a}, 32'h0);
      check("rst_busy", {31'h0, busy_a}, 32'h0);
      check("rst_sda", {31'h0, sda_a}, 32'h1);
      #Q;

      // 16-bit single write
      wr_q_a.delete();
      start_c();
      write_byte(8'h78, ak); check("w16_ack_dev", {31'h0, ak}, 32'h1);
      write_byte(8'h30, ak); check("w16_ack_ah", {31'h0, ak}, 32'h1);
      write_byte(8'h08, ak); check("w16_ack_al", {31'h0, ak}, 32'h1);
      check("w16_busy_mid", {31'h0, busy_a}, 32'h1);
      write_byte(8'h82, ak); check("w16_ack_wr", {31'h0, ak}, 32'h1);
      stop_c();
      check("w16_nstrobe", wr_q_a.size(), 32'd1);
      check("w16_strobe", wr_at(0), 32'h0030_0882);
      check("w16_busy_end", {31'h0, busy_a}, 32'h0);

      // burst write across 16-bit wrap
      wr_q_a.delete();
      start_c();
      write_byte(8'h78, ak); write_byte(8'hFF, ak); write_byte(8'hFF, ak);
      write_byte(8'h11, ak); write_byte(8'h22, ak);
      stop_c();
      check("wrap_nstrobe", wr_q_a.size(), 32'd2);
      check("wrap_strobe0", wr_at(0), 32'h00FF_FF11);
      check("wrap_strobe1", wr_at(1), 32'h0000_0022);

      // random read: address write, repeated START, two bytes
      wr_q_a.delete(); rd_q_a.delete();
      start_c();
      write_byte(8'h78, ak); write_byte(8'h30, ak); write_byte(8'h0A, ak);
      start_c();
      write_byte(8'h79, ak); check("rd_ack_dev", {31'h0, ak}, 32'h1);
      read_byte(1'b1, d); check("rd_byte0", {24'h0, d}, 32'h56);
      read_byte(1'b0, d); check("rd_byte1", {24'h0, d}, 32'h40);
      check("rd_sda_release", {31'h0, sda_in}, 32'h1);
      stop_c();
      check("rd_nreq", rd_q_a.size(), 32'd2);
      check("rd_req0", rd_at(0), 32'h300A);
      check("rd_req1", rd_at(1), 32'h300B);
      check("rd_no_wr", wr_q_a.size(), 32'd0);
      check("rd_busy_end", {31'h0, busy_a}, 32'h0);

      // address mismatch
      wr_q_a.delete(); rd_q_a.delete(); busy_cnt_a = 0;
      start_c();
      write_byte(8'h42, ak); check("mis_nack_dev", {31'h0, ak}, 32'h0);
      write_byte(8'h55, ak); check("mis_nack_dat", {31'h0, ak}, 32'h0);
      stop_c();
      check("mis_no_wr", wr_q_a.size(), 32'd0);
      check("mis_no_rd", rd_q_a.size(), 32'd0);
      check("mis_busy", busy_cnt_a, 32'd0);

      // 8-bit address mode target, plus its 8-bit wrap
      sel = 1'b1; #Q;
      wr_q_b.delete();
      start_c();
      acks = 0;
      write_byte(8'h78, ak); acks += int'(ak);
      write_byte(8'h12, ak); acks += int'(ak);
      write_byte(8'h34, ak); acks += int'(ak);
      stop_c();
      check("m0_acks", acks, 32'd3);
      check("m0_nstrobe", wr_q_b.size(), 32'd1);
      check("m0_strobe", (wr_q_b.size() > 0) ? {8'h0, wr_q_b[0]} : 32'hDEAD_BEEF, 32'h0000_1234);
      check("m0_addr_after", {16'h0, addr_b}, 32'h0013);
      wr_q_b.delete();
      start_c();
      write_byte(8'h78, ak); write_byte(8'hFF, ak);
      write_byte(8'hA1, ak); write_byte(8'hB2, ak);
      stop_c();
      check("m0_wrap_n", wr_q_b.size(), 32'd2);
      check("m0_wrap0", (wr_q_b.size() > 0) ? {8'h0, wr_q_b[0]} : 32'hDEAD_BEEF, 32'h0000_FFA1);
      check("m0_wrap1", (wr_q_b.size() > 1) ? {8'h0, wr_q_b[1]} : 32'hDEAD_BEEF, 32'h0000_00B2);
      sel = 1'b0; #Q;

      // reset during the ACK low phase
      wr_q_a.delete();
      start_c();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h78 >> i), r);
      m_sda_oe = 1'b0;
      #Q;
      check("rst_ack_low", {31'h0, sda_in}, 32'h0);
      @(negedge Clk) Rst_n = 1'b0;
      @(negedge Clk) Rst_n = 1'b1;
      check("rst_mid_sda", {31'h0, sda_in}, 32'h1);
      check("rst_mid_busy", {31'h0, busy_a}, 32'h0);
      check("rst_mid_addr", {16'h0, addr_a}, 32'h0);
      busy_cnt_a = 0;
      m_scl = 1'b1; #Q; #Q; m_scl = 1'b0; #Q;
      write_byte(8'h30, ak); check("rst_ign_ack0", {31'h0, ak}, 32'h0);
      write_byte(8'h08, ak); check("rst_ign_ack1", {31'h0, ak}, 32'h0);
      check("rst_ign_wr", wr_q_a.size(), 32'd0);
      check("rst_ign_busy", busy_cnt_a, 32'd0);
      stop_c();
      start_c();
      write_byte(8'h78, ak); check("rst_fresh_ack", {31'h0, ak}, 32'h1);
      write_byte(8'h00, ak); write_byte(8'h05, ak); write_byte(8'hA5, ak);
      stop_c();
      check("rst_fresh_n", wr_q_a.size(), 32'd1);
      check("rst_fresh_strobe", wr_at(0), 32'h0000_05A5);

      // randomized bursts against the address/memory model
      for (int k = 0; k < 6; k++) begin
         a = (k == 0) ? 16'hFFFE : 16'($urandom);
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         wr_q_a.delete();
         acks = 0;
         start_c();
         write_byte(8'h78, ak); acks += int'(ak);
         write_byte(a[15:8], ak); acks += int'(ak);
         write_byte(a[7:0], ak); acks += int'(ak);
         for (int i = 0; i < n; i++) begin
            write_byte(pay[i], ak); acks += int'(ak);
         end
         stop_c();
         check("rnd_wr_acks", acks, n + 3);
         check("rnd_wr_n", wr_q_a.size(), n);
         for (int i = 0; i < n; i++)
            check("rnd_wr_strobe", wr_at(i), {8'h00, 16'((32'(a) + i) % 65536), pay[i]});
      end

      for (int k = 0; k < 4; k++) begin
         a = (k == 0) ? 16'hFFFF : 16'($urandom);
         n = $urandom_range(1, 3);
         rd_q_a.delete();
         start_c();
         write_byte(8'h78, ak); write_byte(a[15:8], ak); write_byte(a[7:0], ak);
         start_c();
         write_byte(8'h79, ak);
         check("rnd_rd_ack", {31'h0, ak}, 32'h1);
         for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            check("rnd_rd_byte", {24'h0, d}, {24'h0, mem[16'((32'(a) + i) % 65536)]});
         end
         check("rnd_rd_release", {31'h0, sda_in}, 32'h1);
         stop_c();
         check("rnd_rd_n", rd_q_a.size(), n);
         for (int i = 0; i < n; i++)
            check("rnd_rd_req", rd_at(i), (32'(a) + i) % 65536);
      end

      check("b_no_reads", rd_q_b.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
